alu_arbiter: RTL and testbench

- Shares one instance of the team's 32-bit four-function ALU (add/sub/and/or, zero flag) between NUM_REQ requesters using round-robin arbitration.
- Each requester issues operations over a valid/ready handshake and receives its result over a valid/ready handshake.
- Two-stage pipeline: operand register, then response register. Sustained throughput is one operation per cycle.
- Sits between the requesting units (e.g. address-generation and execute paths) and the ALU instance.

---
 rtl/alu_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter that shares it between requesters.
package alu_pkg;

  localparam int ALU_SEL_W = 2;
  localparam int MAX_REQ   = 4;

  typedef logic [ALU_SEL_W-1:0] alu_sel_t;

  localparam alu_sel_t ALU_ADD = 2'b00;
  localparam alu_sel_t ALU_SUB = 2'b01;
  localparam alu_sel_t ALU_AND = 2'b10;
  localparam alu_sel_t ALU_OR  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer (with wrap) for the
// first active request. The pointer advances past the winner only when a
// grant is actually issued, so an idle or stalled cycle does not disturb fairness.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  int               w_cand;

  // Find the first requester at or above the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = int'(r_ptr) + off;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(w_cand);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Drive the one-hot grant only when the downstream stage can take the op.
  always_comb begin
    o_grant        = '0;
    o_grant[w_idx] = w_found & i_enable;
    o_grant_idx    = w_idx;
  end

  // Pointer moves to the requester after the winner on every issued grant.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_enable && w_found) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one four-function ALU between NUM_REQ requesters. Stage 1 holds the
// granted operation and feeds the external ALU; stage 2 captures the ALU
// result and presents it to the owning requester. One op per cycle when the
// response side keeps up; backpressure stalls both stages without loss.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_selector,
  input  logic [DATA_W*NUM_REQ-1:0] req_data_A,
  input  logic [DATA_W*NUM_REQ-1:0] req_data_B,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zeroFlag,
  output logic [DATA_W-1:0]         alu_data_A,
  output logic [DATA_W-1:0]         alu_data_B,
  output logic [ALU_SEL_W-1:0]      alu_selector,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zeroFlag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Stage 1: operand register
  logic               r_op_valid;
  logic [IDX_W-1:0]   r_op_owner;
  alu_sel_t           r_op_sel;
  logic [DATA_W-1:0]  r_op_A;
  logic [DATA_W-1:0]  r_op_B;

  // Stage 2: response register
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_zero;

  logic               w_rsp_taken;
  logic               w_adv2;
  logic               w_can_accept;
  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_owner_oh;
  alu_sel_t           w_sel_in;
  logic [DATA_W-1:0]  w_A_in;
  logic [DATA_W-1:0]  w_B_in;
  int                 w_gidx;

  // rsp_valid is one-hot, so the owner's ready is just the OR of the masked bits.
  assign w_rsp_taken  = |(r_rsp_valid & rsp_ready);
  assign w_adv2       = r_op_valid & (~(|r_rsp_valid) | w_rsp_taken);
  assign w_can_accept = ~r_op_valid | w_adv2;
  // Holding reset keeps every req_ready low regardless of pipeline state.
  assign w_arb_en     = w_can_accept & reset_n;
  assign w_accept     = |w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_req       (req_valid),
    .i_enable    (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Pick the selector and operand slices belonging to the arbitration winner.
  always_comb begin
    w_gidx   = int'(w_grant_idx);
    w_sel_in = req_selector[w_gidx*ALU_SEL_W +: ALU_SEL_W];
    w_A_in   = req_data_A[w_gidx*DATA_W +: DATA_W];
    w_B_in   = req_data_B[w_gidx*DATA_W +: DATA_W];
  end

  // Convert the stage-1 owner index into the one-hot response tag.
  always_comb begin
    w_owner_oh             = '0;
    w_owner_oh[r_op_owner] = 1'b1;
  end

  // Stage 1: load on accept, empty when the op moves on with nothing behind it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_op_valid <= 1'b0;
      r_op_owner <= '0;
      r_op_sel   <= ALU_ADD;
      r_op_A     <= '0;
      r_op_B     <= '0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op_owner <= w_grant_idx;
      r_op_sel   <= w_sel_in;
      r_op_A     <= w_A_in;
      r_op_B     <= w_B_in;
    end else if (w_adv2) begin
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= r_op_valid;
    end
  end

  // Stage 2: capture the ALU result on advance, clear once the owner takes it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
    end else if (w_adv2) begin
      r_rsp_valid <= w_owner_oh;
      r_rsp_data  <= alu_result;
      r_rsp_zero  <= alu_zeroFlag;
    end else if (w_rsp_taken) begin
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign req_ready    = w_grant;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_zeroFlag = r_rsp_zero;
  // ALU inputs come straight from stage 1 and keep their last value when idle.
  assign alu_data_A   = r_op_A;
  assign alu_data_B   = r_op_B;
  assign alu_selector = r_op_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two and four requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clock;
  logic        reset_n;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_selector;
  logic [63:0] req_data_A;
  logic [63:0] req_data_B;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zeroFlag;
  logic [31:0] alu_data_A;
  logic [31:0] alu_data_B;
  logic [1:0]  alu_selector;
  logic [31:0] alu_result;
  logic        alu_zeroFlag;

  logic [3:0]   req_valid4;
  logic [3:0]   req_ready4;
  logic [7:0]   req_selector4;
  logic [127:0] req_data_A4;
  logic [127:0] req_data_B4;
  logic [3:0]   rsp_valid4;
  logic [3:0]   rsp_ready4;
  logic [31:0]  rsp_data4;
  logic         rsp_zeroFlag4;
  logic [31:0]  alu_data_A4;
  logic [31:0]  alu_data_B4;
  logic [1:0]   alu_selector4;
  logic [31:0]  alu_result4;
  logic         alu_zeroFlag4;

  int n_checks;
  int n_fail;

  alu_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_selector(req_selector),
    .req_data_A(req_data_A), .req_data_B(req_data_B),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zeroFlag(rsp_zeroFlag),
    .alu_data_A(alu_data_A), .alu_data_B(alu_data_B), .alu_selector(alu_selector),
    .alu_result(alu_result), .alu_zeroFlag(alu_zeroFlag)
  );

  alu_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_selector(req_selector4),
    .req_data_A(req_data_A4), .req_data_B(req_data_B4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
    .rsp_zeroFlag(rsp_zeroFlag4),
    .alu_data_A(alu_data_A4), .alu_data_B(alu_data_B4), .alu_selector(alu_selector4),
    .alu_result(alu_result4), .alu_zeroFlag(alu_zeroFlag4)
  );

  // Four-function ALU feeding the two-requester instance.
  always_comb begin
    case (alu_selector)
      ALU_ADD: alu_result = alu_data_A + alu_data_B;
      ALU_SUB: alu_result = alu_data_A - alu_data_B;
      ALU_AND: alu_result = alu_data_A & alu_data_B;
      ALU_OR:  alu_result = alu_data_A | alu_data_B;
      default: alu_result = 32'd0;
    endcase
    alu_zeroFlag = (alu_result == 32'd0);
  end

  // Four-function ALU feeding the four-requester instance.
  always_comb begin
    case (alu_selector4)
      ALU_ADD: alu_result4 = alu_data_A4 + alu_data_B4;
      ALU_SUB: alu_result4 = alu_data_A4 - alu_data_B4;
      ALU_AND: alu_result4 = alu_data_A4 & alu_data_B4;
      ALU_OR:  alu_result4 = alu_data_A4 | alu_data_B4;
      default: alu_result4 = 32'd0;
    endcase
    alu_zeroFlag4 = (alu_result4 == 32'd0);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset_n      = 1'b0;
    req_valid    = 2'b00;
    req_valid4   = 4'h0;
    rsp_ready    = 2'b11;
    rsp_ready4   = 4'hF;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    req_valid    = 2'b11;
    req_selector = 4'b0000;
    req_data_A   = 64'h0000_0003_0000_0004;
    req_data_B   = 64'h0000_0001_0000_0001;
    rsp_ready    = 2'b11;
    req_valid4   = 4'h0;
    rsp_ready4   = 4'hF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_checks++;
    if (rsp_data !== 32'd0 || rsp_zeroFlag !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_data got %h/%b exp 0/0", rsp_data, rsp_zeroFlag);
    end
    n_checks++;
    if (alu_data_A !== 32'd0 || alu_data_B !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu_operands got %h/%h exp 0/0", alu_data_A, alu_data_B);
    end
    req_valid = 2'b00;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_op();
    do_reset();
    req_valid    = 2'b01;
    req_selector = {ALU_ADD, ALU_ADD};
    req_data_A   = {32'd0, 32'd5};
    req_data_B   = {32'd0, 32'd7};
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
    @(posedge clock);
    #1 req_valid = 2'b00;
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early got %b exp 00", rsp_valid); end
    n_checks++;
    if (alu_data_A !== 32'd5) begin n_fail++; $display("FAIL single_alu_A got %h exp 5", alu_data_A); end
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_zeroFlag !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp got %b/%h/%b exp 01/0000000c/0", rsp_valid, rsp_data, rsp_zeroFlag);
    end
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_clear got %b exp 00", rsp_valid); end
  endtask

  task automatic test_contention();
    do_reset();
    req_valid    = 2'b11;
    req_selector = {ALU_OR, ALU_SUB};
    req_data_A   = {32'h0000_00F0, 32'd9};
    req_data_B   = {32'h0000_000F, 32'd9};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL contention_grant[%0d] got %b", i, req_ready);
      end
      n_checks++;
      if (i < 2) begin
        if (rsp_valid !== 2'b00) begin
          n_fail++; $display("FAIL contention_rsp_idle[%0d] got %b exp 00", i, rsp_valid);
        end
      end else if (i % 2 == 0) begin
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_zeroFlag !== 1'b1) begin
          n_fail++; $display("FAIL contention_rsp0[%0d] got %b/%h/%b exp 01/0/1", i, rsp_valid, rsp_data, rsp_zeroFlag);
        end
      end else begin
        if (rsp_valid !== 2'b10 || rsp_data !== 32'h0000_00FF || rsp_zeroFlag !== 1'b0) begin
          n_fail++; $display("FAIL contention_rsp1[%0d] got %b/%h/%b exp 10/ff/0", i, rsp_valid, rsp_data, rsp_zeroFlag);
        end
      end
    end
    @(posedge clock);
    #1 req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready    = 2'b00;
    req_valid    = 2'b11;
    req_selector = {ALU_SUB, ALU_ADD};
    req_data_A   = {32'd10, 32'd1};
    req_data_B   = {32'd4, 32'd2};
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_fill0 got %b exp 01", req_ready); end
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_fill1 got %b exp 10", req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
        n_fail++; $display("FAIL bp_stall[%0d] got ready=%b rsp=%b/%h exp 00 01/3", i, req_ready, rsp_valid, rsp_data);
      end
    end
    @(posedge clock);
    #1;
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
      n_fail++; $display("FAIL bp_release0 got %b/%h exp 01/3", rsp_valid, rsp_data);
    end
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'd6) begin
      n_fail++; $display("FAIL bp_release1 got %b/%h exp 10/6", rsp_valid, rsp_data);
    end
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_drained got %b exp 00", rsp_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid    = 2'b10;
    req_selector = {ALU_ADD, ALU_ADD};
    req_data_A   = {32'hFFFF_FFFF, 32'd0};
    req_data_B   = {32'd1, 32'd0};
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wrap_grant got %b exp 10", req_ready); end
    @(posedge clock);
    #1 req_valid = 2'b00;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'd0 || rsp_zeroFlag !== 1'b1) begin
      n_fail++; $display("FAIL wrap_rsp got %b/%h/%b exp 10/0/1", rsp_valid, rsp_data, rsp_zeroFlag);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid    = 2'b01;
    req_selector = {ALU_OR, ALU_AND};
    req_data_A   = {32'h0000_1000, 32'h0000_00F0};
    req_data_B   = {32'h0000_0001, 32'h0000_003C};
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got %b exp 01", req_ready); end
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    req_valid = 2'b11;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready_in_reset got %b exp 00", req_ready); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b00 || alu_data_A !== 32'd0) begin
      n_fail++; $display("FAIL mid_flushed got %b/%h exp 00/0", rsp_valid, alu_data_A);
    end
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset got %b exp 01", req_ready); end
    @(posedge clock);
    #1 req_valid = 2'b00;
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_no_ghost got %b exp 00", rsp_valid); end
    @(negedge clock);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_0030) begin
      n_fail++; $display("FAIL mid_after_rsp got %b/%h exp 01/30", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_four_req();
    logic [31:0] exp_and [4];
    logic [3:0]  exp_oh;
    int          own;
    exp_and[0] = 32'h00FF_0000;
    exp_and[1] = 32'h0F00_0F00;
    exp_and[2] = 32'h0000_5678;
    exp_and[3] = 32'h0000_0000;
    do_reset();
    req_valid4    = 4'hF;
    req_selector4 = {ALU_AND, ALU_AND, ALU_AND, ALU_AND};
    req_data_A4   = {32'hAAAA_AAAA, 32'h1234_5678, 32'h0F0F_0F0F, 32'hFFFF_0000};
    req_data_B4   = {32'h5555_5555, 32'h0000_FFFF, 32'hFF00_FF00, 32'h00FF_FF00};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i < 8) begin
        exp_oh = 4'b0001 << (i % 4);
        n_checks++;
        if (req_ready4 !== exp_oh) begin
          n_fail++; $display("FAIL four_grant[%0d] got %b exp %b", i, req_ready4, exp_oh);
        end
      end else begin
        exp_oh = 4'b0000;
      end
      if (i >= 2) begin
        own    = (i - 2) % 4;
        exp_oh = 4'b0001 << own;
        n_checks++;
        if (rsp_valid4 !== exp_oh || rsp_data4 !== exp_and[own] || rsp_zeroFlag4 !== (own == 3)) begin
          n_fail++; $display("FAIL four_rsp[%0d] got %b/%h/%b exp %b/%h", i, rsp_valid4, rsp_data4, rsp_zeroFlag4, exp_oh, exp_and[own]);
        end
      end
      if (i == 7) begin
        @(posedge clock);
        #1 req_valid4 = 4'h0;
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    req_valid    = 2'b00;
    req_selector = 4'b0000;
    req_data_A   = 64'd0;
    req_data_B   = 64'd0;
    rsp_ready    = 2'b11;
    req_valid4    = 4'h0;
    req_selector4 = 8'h00;
    req_data_A4   = 128'd0;
    req_data_B4   = 128'd0;
    rsp_ready4    = 4'hF;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_four_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
